// File: rtl/osc_pkg.sv
// Shared oscillator constants: waveform selector codes and the pitch word format
// that is also used by the portamento stage.
package osc_pkg;

    localparam int unsigned PITCH_W    = 16;
    localparam int unsigned PITCH_FRAC = 3;

    typedef enum logic [1:0] {
        WAVE_SAW   = 2'd0,
        WAVE_PULSE = 2'd1,
        WAVE_TRI   = 2'd2,
        WAVE_SUB   = 2'd3
    } wave_e;

endpackage

// File: rtl/osc_shaper.sv
// Combinational waveform shaper: turns the top phase bits and the sub level into
// one sample for the selected waveform.
module osc_shaper
    import osc_pkg::*;
#(
    parameter int unsigned OUT_W = 12
) (
    // Top OUT_W+1 bits of the phase accumulator.
    input  logic [OUT_W:0]   ph,
    input  logic             sub,
    input  logic [1:0]       wave_sel,
    input  logic [7:0]       pw,
    output logic [OUT_W-1:0] sample
);

    always_comb begin
        sample = '0;
        unique case (wave_e'(wave_sel))
            WAVE_SAW:   sample = ph[OUT_W:1];
            WAVE_PULSE: sample = {OUT_W{ph[OUT_W -: 8] < pw}};
            WAVE_TRI:   sample = ph[OUT_W] ? ~ph[OUT_W-1:0] : ph[OUT_W-1:0];
            WAVE_SUB:   sample = {OUT_W{sub}};
            default:    sample = '0;
        endcase
    end

endmodule

// File: rtl/osc_core.sv
// Phase-accumulator oscillator: stage 0 accumulates pitch per sample tick, stage 1
// registers the shaped sample, giving a two-edge latency at one sample per cycle.
module osc_core
    import osc_pkg::*;
#(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned OUT_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SAMPLE_TICK,
    input  logic [PITCH_W-1:0] PITCH,
    input  logic [7:0]         PW,
    input  logic [1:0]         WAVE_SEL,
    input  logic               HARD_SYNC,
    output logic [OUT_W-1:0]   OSC_OUT,
    output logic               OSC_VALID,
    output logic               SUB_OUT,
    output logic               WRAP
);

    logic [ACC_W-1:0] acc_q;
    logic             sub_q;
    logic             wrap_q;
    logic             tick_q;
    logic [OUT_W-1:0] osc_out_q;
    logic             osc_valid_q;
    logic             sub_out_q;

    logic [ACC_W:0]   sum;
    logic [OUT_W-1:0] sample;

    // Extra MSB of the sum is the accumulator carry-out.
    assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - PITCH_W){1'b0}}, PITCH};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            sub_q  <= 1'b0;
            wrap_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            tick_q <= SAMPLE_TICK;
            if (SAMPLE_TICK) begin
                if (HARD_SYNC) begin
                    acc_q <= '0;
                    sub_q <= 1'b0;
                end else begin
                    acc_q  <= sum[ACC_W-1:0];
                    wrap_q <= sum[ACC_W];
                    sub_q  <= sub_q ^ sum[ACC_W];
                end
            end
        end
    end

    osc_shaper #(
        .OUT_W (OUT_W)
    ) u_shaper (
        .ph       (acc_q[ACC_W-1 -: OUT_W+1]),
        .sub      (sub_q),
        .wave_sel (WAVE_SEL),
        .pw       (PW),
        .sample   (sample)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osc_out_q   <= '0;
            osc_valid_q <= 1'b0;
            sub_out_q   <= 1'b0;
        end else begin
            osc_valid_q <= tick_q;
            if (tick_q) begin
                osc_out_q <= sample;
                sub_out_q <= sub_q;
            end
        end
    end

    assign OSC_OUT   = osc_out_q;
    assign OSC_VALID = osc_valid_q;
    assign SUB_OUT   = sub_out_q;
    assign WRAP      = wrap_q;

endmodule

// File: doc/osc_core.md
# osc_core

Phase-accumulator oscillator that consumes the 16-bit glided pitch word produced by the portamento stage (`PORT.GEN_OUT`) and renders one audio-rate waveform sample per sample tick. It is the next stage in the voice chain, between the portamento generator and the output mixer/DAC interface. It provides saw, variable-width pulse, triangle and a one-octave-down square sub-oscillator, plus a hard-sync input.

## Interface
- `ACC_W`, default 24: phase accumulator width in bits. Minimum is 17.
- `OUT_W`, default 12: output sample width in bits. Unsigned offset-binary.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset. One clock domain only.
- `SAMPLE_TICK` in 1: single-cycle strobe that advances the oscillator by one sample. It may be asserted on every cycle.
- `PITCH` in 16: phase increment per tick, in {13-bit integer, 3-bit fraction} format, driven by `PORT.GEN_OUT`.
- `PW` in 8: pulse width threshold.
- `WAVE_SEL` in 2: waveform select. 0 = saw, 1 = pulse, 2 = triangle, 3 = sub.
- `HARD_SYNC` in 1: qualified by `SAMPLE_TICK`. Resets the phase.
- `OSC_OUT` out `OUT_W`: registered sample.
- `OSC_VALID` out 1: one-cycle strobe marking a new `OSC_OUT`.
- `SUB_OUT` out 1: sub-oscillator level. Toggles on each phase wrap.
- `WRAP` out 1: one-cycle strobe marking an accumulator carry-out.

## Operation
- **Reset values.**
  - `ACC` = 0 and `sub` = 0.
  - `OSC_OUT` = 0, `OSC_VALID` = 0, `SUB_OUT` = 0, `WRAP` = 0.
- **Stage 0 (accumulate).** On an edge where `SAMPLE_TICK` is 1:
  - `ACC <= (ACC + zero_ext(PITCH)) mod 2^ACC_W`.
  - `PITCH` is sampled only on tick edges. Changes between ticks have no effect.
  - Carry-out → `WRAP` = 1 for that cycle, and `sub` toggles.
  - No tick → `ACC`, `sub` hold and `WRAP` = 0.
  - `PITCH` = 0 → `ACC` holds, no wrap, and `OSC_VALID` still pulses.
- **Hard sync.** A tick with `HARD_SYNC` = 1 sets `ACC` = 0 and `sub` = 0, and `WRAP` = 0. Sync takes priority over the increment. `HARD_SYNC` without a tick is ignored.
- **Stage 1 (shape), registered.** Let `ph` = top `OUT_W` bits of `ACC`. `OSC_OUT` is selected by `WAVE_SEL` (sampled at the stage-1 edge):
  - saw = `ph`.
  - pulse = all-ones if `ACC[ACC_W-1 -: 8] < PW`, else 0. `PW` = 0 gives a constant 0. `PW` = 255 gives a low output only when the top byte is 8'hFF.
  - triangle = `ACC[ACC_W-1]` ? ~`ACC[ACC_W-2 -: OUT_W]` : `ACC[ACC_W-2 -: OUT_W]`.
  - sub = all-ones if `sub` = 1, else 0.
- **Sub output.** `SUB_OUT` mirrors `sub`, registered together with `OSC_OUT`.
- **Out-of-range `WAVE_SEL`.** None exists, since the 2-bit field is fully decoded.

## Timing
- A tick sampled at edge N updates `ACC`/`sub` at edge N. `WRAP` is high during cycle N→N+1.
- `OSC_OUT`, `SUB_OUT` and `OSC_VALID` update at edge N+1. `OSC_VALID` is high for exactly cycle N+1→N+2, so latency is 2 edges.
- Back-to-back ticks give a throughput of 1 sample per cycle. `OSC_VALID` stays high continuously and each cycle carries a distinct sample.
- Between ticks, `OSC_OUT` holds its last value.
- An asynchronous reset mid-stream clears everything immediately. The first tick after release behaves as from `ACC` = 0.

## Structure
- Shared package `osc_pkg`:
  - `WAVE_SAW`/`WAVE_PULSE`/`WAVE_TRI`/`WAVE_SUB` constants.
  - The `PITCH_W` = 16 and `PITCH_FRAC` = 3 constants, which are shared with the portamento stage.
- One sub-module, `osc_shaper`: the combinational waveform mux and compare. `osc_core` owns the accumulator, the sub flip-flop and all output registers.

## Test plan
- **Reset.** Hold `rst_n` = 0 with `SAMPLE_TICK` toggling → all outputs stay 0. Release, then give one tick with `PITCH` = 16'h8000 and saw selected → `OSC_OUT` = 12'h008 and `OSC_VALID` pulses exactly 2 edges after the tick.
- **Wrap / sub.** `PITCH` = 16'h8000 with continuous ticks:
  - `WRAP` pulses every 512 ticks.
  - `SUB_OUT` toggles on each wrap, giving a period of 1024 ticks.
  - With `WAVE_SEL` = 3, `OSC_OUT` alternates 12'hFFF / 12'h000 on the same cadence.
- **Pulse width.**
  - `PW` = 8'h80 → high for 256 of 512 ticks per cycle.
  - `PW` = 0 → `OSC_OUT` is always 0.
  - `PW` = 8'hFF → low only on ticks where the top byte is FF.
- **Triangle.** `PITCH` = 16'h8000 → `OSC_OUT` peaks at 12'hFFF near `ACC` = 0x7FF800 and falls back to 12'h000 at wrap. The shape is symmetric.
- **Hard sync.** With `ACC` = 0x400000, a tick with `HARD_SYNC` = 1 → `ACC` = 0, `sub` = 0, no `WRAP`, and saw `OSC_OUT` = 0.
- **Stall / pitch change.**
  - No ticks for 50 cycles → `ACC` and `OSC_OUT` hold and `OSC_VALID` stays 0.
  - `PITCH` changed between ticks → only the value present at a tick is accumulated.
